// File: rtl/axil_sram_slave_pkg.sv
// Shared definitions for the AXI4-lite SRAM responder: response codes, FSM
// encodings and the LFSR/delay helpers used by both channels.
package axil_sram_slave_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DELAY = 2'd1,
        R_RESP  = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_COLLECT = 2'd0,
        W_DELAY   = 2'd1,
        W_RESP    = 2'd2
    } w_state_t;

    // Galois step: shift right, fold the taps in when a one falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // Low DELAY_BITS of the LFSR; bits == 0 yields a constant zero delay.
    function automatic logic [7:0] delay_lo(input logic [15:0] v, input int bits);
        return 8'(v & ((16'd1 << bits) - 16'd1));
    endfunction

    // Top DELAY_BITS of the LFSR; a 16-place shift leaves zero when bits == 0.
    function automatic logic [7:0] delay_hi(input logic [15:0] v, input int bits);
        return 8'(v >> (16 - bits));
    endfunction

endpackage

// File: rtl/axil_sram_slave_if.sv
// AXI4-lite load/store bus between the write-back stage master and the SRAM
// responder. Every channel completes on the edge where valid && ready.
interface axil_sram_slave_if;

    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_awaddr;
    logic        mem_awvalid;
    logic        mem_awready;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [1:0]  mem_bresp;
    logic        mem_bvalid;
    logic        mem_bready;

    modport slave (
        input  mem_araddr, mem_arvalid, mem_rready,
        input  mem_awaddr, mem_awvalid, mem_wdata, mem_wstrb, mem_wvalid, mem_bready,
        output mem_arready, mem_rdata, mem_rresp, mem_rvalid,
        output mem_awready, mem_wready, mem_bresp, mem_bvalid
    );

    modport master (
        output mem_araddr, mem_arvalid, mem_rready,
        output mem_awaddr, mem_awvalid, mem_wdata, mem_wstrb, mem_wvalid, mem_bready,
        input  mem_arready, mem_rdata, mem_rresp, mem_rvalid,
        input  mem_awready, mem_wready, mem_bresp, mem_bvalid
    );

endinterface

// File: rtl/axil_sram_slave_lfsr16.sv
// Free-running 16-bit Galois LFSR; one instance feeds both channel delays.
module lfsr16
    import axil_sram_slave_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-lite responder over a word-addressed SRAM with independent read and
// write channels, each adding an LFSR-drawn latency before responding.
module axil_sram_slave
    import axil_sram_slave_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DELAY_BITS  = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    axil_sram_slave_if.slave  bus,
    output r_state_t          o_dbg_r_state,
    output w_state_t          o_dbg_w_state
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [15:0] w_lfsr;
    logic [7:0]  w_d_r;
    logic [7:0]  w_d_w;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_lfsr (w_lfsr)
    );

    assign w_d_r = delay_lo(w_lfsr, DELAY_BITS);
    assign w_d_w = delay_hi(w_lfsr, DELAY_BITS);

    // ------------------------------------------------------------------ read
    r_state_t          r_r_state;
    r_state_t          w_r_state_n;
    logic [31:0]       r_araddr;
    logic [7:0]        r_r_cnt;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rvalid;
    logic              w_arready;
    logic              w_ar_hs;
    logic              w_r_dec;
    logic              w_r_capture;
    logic              w_r_done;
    logic [31:0]       w_r_off;
    logic [IDX_W-1:0]  w_r_idx;
    logic              w_r_hit;

    assign w_arready = (r_r_state == R_IDLE);
    assign w_ar_hs   = w_arready && bus.mem_arvalid;
    assign w_r_off   = r_araddr - BASE_ADDR;
    assign w_r_idx   = w_r_off[IDX_W+1:2];
    assign w_r_hit   = ({1'b0, w_r_off} < SPAN);

    always_comb begin
        w_r_state_n = r_r_state;
        w_r_dec     = 1'b0;
        w_r_capture = 1'b0;
        w_r_done    = 1'b0;
        case (r_r_state)
            R_IDLE: begin
                if (w_ar_hs) w_r_state_n = R_DELAY;
            end
            R_DELAY: begin
                if (r_r_cnt == 8'd0) begin
                    w_r_capture = 1'b1;
                    w_r_state_n = R_RESP;
                end else begin
                    w_r_dec = 1'b1;
                end
            end
            R_RESP: begin
                if (bus.mem_rready) begin
                    w_r_done    = 1'b1;
                    w_r_state_n = R_IDLE;
                end
            end
            default: w_r_state_n = R_IDLE;
        endcase
    end

    // The capture reads r_mem before any same-edge write commit lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r_state <= R_IDLE;
            r_araddr  <= 32'd0;
            r_r_cnt   <= 8'd0;
            r_rdata   <= 32'd0;
            r_rresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
        end else begin
            r_r_state <= w_r_state_n;
            if (w_ar_hs) begin
                r_araddr <= bus.mem_araddr;
                r_r_cnt  <= w_d_r;
            end else if (w_r_dec) begin
                r_r_cnt <= r_r_cnt - 8'd1;
            end
            if (w_r_capture) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_r_hit ? r_mem[w_r_idx] : 32'd0;
                r_rresp  <= w_r_hit ? RESP_OKAY : RESP_DECERR;
            end else if (w_r_done) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------------------- write
    w_state_t          r_w_state;
    w_state_t          w_w_state_n;
    logic              r_aw_held;
    logic              r_w_held;
    logic [31:0]       r_awaddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [7:0]        r_w_cnt;
    logic [1:0]        r_bresp;
    logic              r_bvalid;
    logic              w_awready;
    logic              w_wready;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_w_load;
    logic              w_w_dec;
    logic              w_commit;
    logic              w_b_done;
    logic [31:0]       w_w_off;
    logic [IDX_W-1:0]  w_w_idx;
    logic              w_w_hit;
    logic              w_unused_wstrb;

    assign w_awready      = (r_w_state == W_COLLECT) && !r_aw_held;
    assign w_wready       = (r_w_state == W_COLLECT) && !r_w_held;
    assign w_aw_hs        = w_awready && bus.mem_awvalid;
    assign w_w_hs         = w_wready && bus.mem_wvalid;
    assign w_w_off        = r_awaddr - BASE_ADDR;
    assign w_w_idx        = w_w_off[IDX_W+1:2];
    assign w_w_hit        = ({1'b0, w_w_off} < SPAN);
    assign w_unused_wstrb = ^bus.mem_wstrb[7:4];

    always_comb begin
        w_w_state_n = r_w_state;
        w_w_load    = 1'b0;
        w_w_dec     = 1'b0;
        w_commit    = 1'b0;
        w_b_done    = 1'b0;
        case (r_w_state)
            W_COLLECT: begin
                if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
                    w_w_load    = 1'b1;
                    w_w_state_n = W_DELAY;
                end
            end
            W_DELAY: begin
                if (r_w_cnt == 8'd0) begin
                    w_commit    = 1'b1;
                    w_w_state_n = W_RESP;
                end else begin
                    w_w_dec = 1'b1;
                end
            end
            W_RESP: begin
                if (bus.mem_bready) begin
                    w_b_done    = 1'b1;
                    w_w_state_n = W_COLLECT;
                end
            end
            default: w_w_state_n = W_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_state <= W_COLLECT;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_w_cnt   <= 8'd0;
            r_bresp   <= RESP_OKAY;
            r_bvalid  <= 1'b0;
        end else begin
            r_w_state <= w_w_state_n;
            if (w_aw_hs) begin
                r_awaddr  <= bus.mem_awaddr;
                r_aw_held <= 1'b1;
            end
            if (w_w_hs) begin
                r_wdata  <= bus.mem_wdata;
                r_wstrb  <= bus.mem_wstrb[3:0];
                r_w_held <= 1'b1;
            end
            if (w_w_load) begin
                r_w_cnt <= w_d_w;
            end else if (w_w_dec) begin
                r_w_cnt <= r_w_cnt - 8'd1;
            end
            if (w_commit) begin
                r_bvalid  <= 1'b1;
                r_bresp   <= w_w_hit ? RESP_OKAY : RESP_DECERR;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end else if (w_b_done) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // SRAM array has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_commit && w_w_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i]) r_mem[w_w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign bus.mem_arready = w_arready;
    assign bus.mem_rdata   = r_rdata;
    assign bus.mem_rresp   = r_rresp;
    assign bus.mem_rvalid  = r_rvalid;
    assign bus.mem_awready = w_awready;
    assign bus.mem_wready  = w_wready;
    assign bus.mem_bresp   = r_bresp;
    assign bus.mem_bvalid  = r_bvalid;

    assign o_dbg_r_state = r_r_state;
    assign o_dbg_w_state = r_w_state;

endmodule
